// File: rtl/apb_rr_master_arbiter_if.sv
// Bundle of requester req/done handshake and APB bus signals for apb_rr_master_arbiter.
// master = arbiter view, slave = requesters plus peripheral view.
interface apb_rr_master_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 12,
    parameter int DATA_W  = 32
);
    logic [NUM_REQ-1:0]            req;
    logic [NUM_REQ-1:0]            req_write;
    logic [NUM_REQ*ADDR_W-1:0]     req_addr;
    logic [NUM_REQ*DATA_W-1:0]     req_wdata;
    logic [NUM_REQ*DATA_W/8-1:0]   req_strb;
    logic [NUM_REQ*3-1:0]          req_prot;
    logic [NUM_REQ-1:0]            done;
    logic [DATA_W-1:0]             rsp_rdata;
    logic                          rsp_err;

    logic                          psel;
    logic                          penable;
    logic                          pwrite;
    logic [ADDR_W-1:0]             paddr;
    logic [DATA_W-1:0]             pwdata;
    logic [DATA_W/8-1:0]           pstrb;
    logic [2:0]                    pprot;
    logic [DATA_W-1:0]             prdata;
    logic                          pready;
    logic                          pslverr;

    modport master (
        input  req, req_write, req_addr, req_wdata, req_strb, req_prot,
        input  prdata, pready, pslverr,
        output done, rsp_rdata, rsp_err,
        output psel, penable, pwrite, paddr, pwdata, pstrb, pprot
    );

    modport slave (
        output req, req_write, req_addr, req_wdata, req_strb, req_prot,
        output prdata, pready, pslverr,
        input  done, rsp_rdata, rsp_err,
        input  psel, penable, pwrite, paddr, pwdata, pstrb, pprot
    );
endinterface

// File: rtl/apb_rr_master_arbiter.sv
// Round-robin arbiter sharing one APB master port among NUM_REQ req/done requesters.
// Define APB_ARB_TIMEOUT_EN to abort ACCESS phases that run TIMEOUT_CYCLES without pready.
module apb_rr_master_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int ADDR_W         = 12,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input logic                     pclk,
    input logic                     presetn,
    apb_rr_master_arbiter_if.master bus
);
    // state  | meaning
    // IDLE   | no transfer in flight; arbitrate and latch the winner's payload
    // SETUP  | APB setup phase (psel=1, penable=0)
    // ACCESS | APB access phase, holding until pready (or timeout abort)
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETUP  = 2'd1;
    localparam logic [1:0] ST_ACCESS = 2'd2;

    localparam int PTR_W  = $clog2(NUM_REQ);
    localparam int STRB_W = DATA_W / 8;

    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1 || (DATA_W % 8) != 0) begin : g_param_check
        $error("apb_rr_master_arbiter: parameter out of range");
    end

    logic [1:0]         state;
    logic [PTR_W-1:0]   ptr;
    logic [PTR_W-1:0]   winner;
    logic [PTR_W-1:0]   pick;
    logic [PTR_W-1:0]   cand;
    logic [PTR_W-1:0]   ptr_next;
    logic [NUM_REQ-1:0] elig;
    logic               any_req;
    logic               to_tc;

    function automatic logic [PTR_W-1:0] rr_index(input logic [PTR_W-1:0] base, input int off);
        int sum;
        sum = int'(base) + off;
        if (sum >= NUM_REQ) sum = sum - NUM_REQ;
        return PTR_W'(sum);
    endfunction

    // A requester still holds req during its own done cycle; masking it avoids a spurious re-grant.
    assign elig = bus.req & ~bus.done;

    always_comb begin
        any_req = 1'b0;
        pick    = ptr;
        cand    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = rr_index(ptr, i);
            if (!any_req && elig[cand]) begin
                any_req = 1'b1;
                pick    = cand;
            end
        end
    end

    assign ptr_next = (winner == PTR_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;

`ifdef APB_ARB_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0] to_cnt;
    assign to_tc = (to_cnt == '0);
`else
    assign to_tc = 1'b0;
`endif

    always_ff @(posedge pclk) begin
        if (!presetn) begin
            state         <= ST_IDLE;
            ptr           <= '0;
            winner        <= '0;
            bus.psel      <= 1'b0;
            bus.penable   <= 1'b0;
            bus.pwrite    <= 1'b0;
            bus.paddr     <= '0;
            bus.pwdata    <= '0;
            bus.pstrb     <= '0;
            bus.pprot     <= '0;
            bus.done      <= '0;
            bus.rsp_rdata <= '0;
            bus.rsp_err   <= 1'b0;
`ifdef APB_ARB_TIMEOUT_EN
            to_cnt        <= '0;
`endif
        end else begin
            bus.done      <= '0;
            bus.rsp_rdata <= '0;
            bus.rsp_err   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (any_req) begin
                        winner     <= pick;
                        bus.pwrite <= bus.req_write[pick];
                        bus.paddr  <= bus.req_addr[int'(pick)*ADDR_W +: ADDR_W];
                        bus.pwdata <= bus.req_wdata[int'(pick)*DATA_W +: DATA_W];
                        bus.pstrb  <= bus.req_write[pick] ?
                                      bus.req_strb[int'(pick)*STRB_W +: STRB_W] : '0;
                        bus.pprot  <= bus.req_prot[int'(pick)*3 +: 3];
                        bus.psel   <= 1'b1;
                        state      <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    bus.penable <= 1'b1;
                    state       <= ST_ACCESS;
`ifdef APB_ARB_TIMEOUT_EN
                    to_cnt      <= TO_W'(TIMEOUT_CYCLES - 1);
`endif
                end
                ST_ACCESS: begin
                    // pready wins over the terminal count, so a late response is still a normal completion
                    if (bus.pready || to_tc) begin
                        bus.psel         <= 1'b0;
                        bus.penable      <= 1'b0;
                        bus.done[winner] <= 1'b1;
                        bus.rsp_err      <= bus.pready ? bus.pslverr : 1'b1;
                        bus.rsp_rdata    <= (bus.pready && !bus.pwrite) ? bus.prdata : '0;
                        ptr              <= ptr_next;
                        state            <= ST_IDLE;
                    end
`ifdef APB_ARB_TIMEOUT_EN
                    else begin
                        to_cnt <= to_cnt - 1'b1;
                    end
`endif
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_apb_rr_master_arbiter.sv
// Self-checking bench for apb_rr_master_arbiter: transaction-level model compared every cycle,
// plus directed scenarios with hand-computed latencies, grant orders and response values.
module tb_apb_rr_master_arbiter;
    localparam int N      = 4;
    localparam int AW     = 12;
    localparam int DW     = 32;
    localparam int SW     = DW / 8;
    localparam int TO_CYC = 8;
`ifdef APB_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic pclk;
    logic presetn;

    apb_rr_master_arbiter_if #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) bus ();

    apb_rr_master_arbiter #(
        .NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO_CYC)
    ) dut (
        .pclk(pclk),
        .presetn(presetn),
        .bus(bus)
    );

    int          n_checks = 0;
    int          n_errors = 0;
    logic        chk_en = 1'b0;
    logic [N-1:0] seen_done = '0;
    logic [N-1:0] keep = '0;
    int          wait_cfg = 0;
    int          acc = 0;
    logic [DW-1:0] rdata_cfg = '0;
    logic        err_cfg = 1'b0;

    initial begin
        pclk = 1'b0;
        forever #5 pclk = ~pclk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, expv);
        end
    endtask

    // ---------------- transaction-level model ----------------
    int           m_age;    // cycles since grant (0 = bus idle)
    int           m_acc;
    int           m_win;
    int           m_ptr;
    int           m_cand;
    bit           m_found;
    logic [N-1:0] m_prev;
    logic [N-1:0] exp_done;
    logic         exp_psel, exp_penable, exp_pwrite, exp_err;
    logic [AW-1:0] exp_paddr;
    logic [DW-1:0] exp_pwdata, exp_rdata;
    logic [SW-1:0] exp_pstrb;
    logic [2:0]   exp_pprot;

    initial begin
        m_age = 0; m_acc = 0; m_win = 0; m_ptr = 0;
        forever begin
            @(posedge pclk);
            if (!presetn) begin
                m_age = 0; m_ptr = 0; m_win = 0; m_acc = 0;
                exp_done = '0; exp_rdata = '0; exp_err = 1'b0;
                exp_pwrite = 1'b0; exp_paddr = '0; exp_pwdata = '0;
                exp_pstrb = '0; exp_pprot = '0;
            end else begin
                m_prev    = exp_done;
                exp_done  = '0;
                exp_rdata = '0;
                exp_err   = 1'b0;
                if (m_age == 0) begin
                    m_found = 1'b0;
                    for (int o = 0; o < N; o++) begin
                        m_cand = (m_ptr + o) % N;
                        if (!m_found && bus.req[m_cand] && !m_prev[m_cand]) begin
                            m_found = 1'b1;
                            m_win   = m_cand;
                        end
                    end
                    if (m_found) begin
                        exp_pwrite = bus.req_write[m_win];
                        exp_paddr  = bus.req_addr[m_win*AW +: AW];
                        exp_pwdata = bus.req_wdata[m_win*DW +: DW];
                        exp_pstrb  = exp_pwrite ? bus.req_strb[m_win*SW +: SW] : '0;
                        exp_pprot  = bus.req_prot[m_win*3 +: 3];
                        m_age      = 1;
                    end
                end else if (m_age == 1) begin
                    m_age = 2;
                    m_acc = 0;
                end else begin
                    m_acc++;
                    if (bus.pready) begin
                        exp_done[m_win] = 1'b1;
                        exp_rdata = exp_pwrite ? '0 : bus.prdata;
                        exp_err   = bus.pslverr;
                        m_age     = 0;
                        m_ptr     = (m_win + 1) % N;
                    end else if (TO_EN && m_acc >= TO_CYC) begin
                        exp_done[m_win] = 1'b1;
                        exp_err   = 1'b1;
                        m_age     = 0;
                        m_ptr     = (m_win + 1) % N;
                    end
                end
            end
            exp_psel    = (m_age >= 1);
            exp_penable = (m_age >= 2);
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        forever begin
            @(negedge pclk);
            seen_done = bus.done;
            if (chk_en) begin
                chk("psel",      bus.psel,      exp_psel);
                chk("penable",   bus.penable,   exp_penable);
                chk("done",      bus.done,      exp_done);
                chk("rsp_rdata", bus.rsp_rdata, exp_rdata);
                chk("rsp_err",   bus.rsp_err,   exp_err);
                if (exp_psel) begin
                    chk("pwrite", bus.pwrite, exp_pwrite);
                    chk("paddr",  bus.paddr,  exp_paddr);
                    chk("pwdata", bus.pwdata, exp_pwdata);
                    chk("pstrb",  bus.pstrb,  exp_pstrb);
                    chk("pprot",  bus.pprot,  exp_pprot);
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge pclk);
        #1;
        for (int i = 0; i < N; i++)
            if (seen_done[i] && !keep[i]) bus.req[i] = 1'b0;
        if (bus.psel && bus.penable) begin
            bus.pready  = (acc == wait_cfg);
            bus.prdata  = rdata_cfg;
            bus.pslverr = err_cfg;
            acc++;
        end else begin
            acc         = 0;
            bus.pready  = 1'b0;
            bus.prdata  = '0;
            bus.pslverr = 1'b0;
        end
    endtask

    task automatic set_req(input int i, input logic wr, input logic [AW-1:0] a,
                           input logic [DW-1:0] d, input logic [SW-1:0] s, input logic [2:0] p);
        bus.req_write[i]         = wr;
        bus.req_addr[i*AW +: AW] = a;
        bus.req_wdata[i*DW +: DW] = d;
        bus.req_strb[i*SW +: SW] = s;
        bus.req_prot[i*3 +: 3]   = p;
        bus.req[i]               = 1'b1;
    endtask

    task automatic wait_done(input int limit, output int k, output int np, output logic [N-1:0] dn);
        k = -1; np = 0; dn = '0;
        for (int c = 1; c <= limit; c++) begin
            step();
            @(negedge pclk);
            if (bus.psel) np++;
            if (bus.done !== '0) begin
                k  = c;
                dn = bus.done;
                break;
            end
        end
        if (k < 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL wait_done: no done within %0d cycles", limit);
        end
    endtask

    function automatic int oh_idx(input logic [N-1:0] v);
        for (int j = 0; j < N; j++) if (v[j]) return j;
        return -1;
    endfunction

    // ---------------- directed scenarios ----------------
    int           k, np;
    logic [N-1:0] dn;
    int           order[5];
    int           exp_order[5];
    int           cnt[N];

    initial begin
        exp_order = '{0, 1, 2, 3, 0};
        presetn = 1'b0;
        bus.req = '0; bus.req_write = '0; bus.req_addr = '0; bus.req_wdata = '0;
        bus.req_strb = '0; bus.req_prot = '0;
        bus.prdata = '0; bus.pready = 1'b0; bus.pslverr = 1'b0;

        step();
        chk_en = 1'b1;
        step();
        @(negedge pclk);
        chk("rst_psel", bus.psel, 1'b0);
        chk("rst_done", bus.done, 4'b0000);
        chk("rst_paddr", bus.paddr, 12'h000);
        presetn = 1'b1;

        // single read with immediate pready
        wait_cfg = 0; rdata_cfg = 32'hDEADBEEF; err_cfg = 1'b0;
        set_req(0, 1'b0, 12'h010, 32'h0, 4'hF, 3'd2);
        wait_done(20, k, np, dn);
        chk("t1_latency", k, 3);
        chk("t1_psel_cycles", np, 2);
        chk("t1_done", dn, 4'b0001);
        chk("t1_rdata", bus.rsp_rdata, 32'hDEADBEEF);
        chk("t1_err", bus.rsp_err, 1'b0);
        step(); step();

        // write with four wait states
        wait_cfg = 4;
        set_req(1, 1'b1, 12'hFFC, 32'hA5A5_5A5A, 4'hF, 3'd1);
        wait_done(20, k, np, dn);
        chk("t2_latency", k, 7);
        chk("t2_done", dn, 4'b0010);
        chk("t2_rdata", bus.rsp_rdata, 32'h0);
        step(); step();

        // slave error on a read, then a clean transfer
        wait_cfg = 0; rdata_cfg = 32'h1234_5678; err_cfg = 1'b1;
        set_req(2, 1'b0, 12'h204, 32'h0, 4'h3, 3'd5);
        wait_done(20, k, np, dn);
        chk("t4_done", dn, 4'b0100);
        chk("t4_err", bus.rsp_err, 1'b1);
        chk("t4_rdata", bus.rsp_rdata, 32'h1234_5678);
        err_cfg = 1'b0;
        step();
        set_req(2, 1'b0, 12'h208, 32'h0, 4'h0, 3'd5);
        wait_done(20, k, np, dn);
        chk("t4b_err", bus.rsp_err, 1'b0);
        step(); step();

        // contention from pointer 0
        presetn = 1'b0;
        step();
        presetn = 1'b1;
        rdata_cfg = 32'h0BAD_F00D;
        keep = 4'b1111;
        for (int i = 0; i < N; i++)
            set_req(i, i[0], AW'(12'h100 + i*4), DW'(32'h1111_0000 + i), SW'(i + 1), 3'(i));
        for (int i = 0; i < N; i++) cnt[i] = 0;
        for (int t = 0; t < 5; t++) begin
            wait_done(10, k, np, dn);
            order[t] = oh_idx(dn);
            if (order[t] >= 0) cnt[order[t]]++;
            chk($sformatf("t3_latency%0d", t), k, 3);
            chk($sformatf("t3_grant%0d", t), order[t], exp_order[t]);
            if (t == 3)
                for (int i = 0; i < N; i++) chk($sformatf("t3_count%0d", i), cnt[i], 1);
        end
        // requester 1 is latched at the next edge, then drops req; it must still complete
        step();
        bus.req = '0;
        keep = '0;
        wait_done(10, k, np, dn);
        chk("t3_drop_done", dn, 4'b0010);
        chk("t3_drop_latency", k, 2);
        step(); step();

        // reset in the middle of an ACCESS phase
        wait_cfg = 9999;
        set_req(3, 1'b1, 12'h3F0, 32'hFEED_BEEF, 4'hC, 3'd7);
        for (int c = 0; c < 10; c++) begin
            step();
            @(negedge pclk);
            if (bus.penable) break;
        end
        chk("t5_in_access", bus.penable, 1'b1);
        step(); step();
        @(negedge pclk);
        presetn = 1'b0;
        bus.req = '0;
        step();
        @(negedge pclk);
        chk("t5_psel", bus.psel, 1'b0);
        chk("t5_penable", bus.penable, 1'b0);
        chk("t5_done", bus.done, 4'b0000);
        presetn = 1'b1;
        wait_cfg = 0;
        step();
        set_req(1, 1'b0, 12'h044, 32'h0, 4'h0, 3'd0);
        set_req(3, 1'b0, 12'h048, 32'h0, 4'h0, 3'd0);
        wait_done(20, k, np, dn);
        chk("t5_first_after_rst", dn, 4'b0010);
        wait_done(20, k, np, dn);
        chk("t5_second_after_rst", dn, 4'b1000);
        step(); step();

`ifdef APB_ARB_TIMEOUT_EN
        // pready never arrives: abort after TO_CYC access cycles
        wait_cfg = 9999; rdata_cfg = 32'hCAFE_F00D;
        set_req(0, 1'b0, 12'h0A0, 32'h0, 4'h0, 3'd0);
        wait_done(40, k, np, dn);
        chk("t6_latency", k, 2 + TO_CYC);
        chk("t6_done", dn, 4'b0001);
        chk("t6_err", bus.rsp_err, 1'b1);
        chk("t6_rdata", bus.rsp_rdata, 32'h0);
        step(); step();
        // pready on the terminal cycle is a normal completion
        wait_cfg = TO_CYC - 1;
        set_req(1, 1'b0, 12'h0A4, 32'h0, 4'h0, 3'd0);
        wait_done(40, k, np, dn);
        chk("t6b_latency", k, 2 + TO_CYC);
        chk("t6b_err", bus.rsp_err, 1'b0);
        chk("t6b_rdata", bus.rsp_rdata, 32'hCAFE_F00D);
`else
        // without the timeout a long wait still completes normally
        wait_cfg = 20; rdata_cfg = 32'hCAFE_F00D;
        set_req(0, 1'b0, 12'h0A0, 32'h0, 4'h0, 3'd0);
        wait_done(60, k, np, dn);
        chk("t6_latency", k, 23);
        chk("t6_err", bus.rsp_err, 1'b0);
        chk("t6_rdata", bus.rsp_rdata, 32'hCAFE_F00D);
`endif
        step(); step(); step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
